// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the PC generation stage: FSM state type,
// sequential step size and the flush-counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam int unsigned FLUSH_CTR_W = 3;

    // Instruction fetch is word-granular, so the low two address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/flush_ctr.sv
// Loadable down-counter that times the squash window following a redirect.
// The squash flag freezes while the pipeline is held, but the count keeps running.
module flush_ctr
    import pipe_pkg::*;
#(
    parameter int unsigned LOAD_VALUE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   hold_i,
    input  logic                   clear_i,
    output logic [FLUSH_CTR_W-1:0] count_o,
    output logic                   squash_o
);

    localparam logic [FLUSH_CTR_W-1:0] LoadCount = FLUSH_CTR_W'(LOAD_VALUE);

    logic [FLUSH_CTR_W-1:0] count_q, count_d;
    logic                   squash_q, squash_d;

    always_comb begin
        count_d  = count_q;
        squash_d = squash_q;
        if (clear_i) begin
            count_d  = '0;
            squash_d = 1'b0;
        end else if (load_i) begin
            count_d  = LoadCount;
            squash_d = 1'b1;
        end else begin
            if (count_q != '0) begin
                count_d = count_q - FLUSH_CTR_W'(1);
            end
            // Squash stays up while the count is above one, i.e. for LOAD_VALUE slots.
            if (!hold_i) begin
                squash_d = (count_q > FLUSH_CTR_W'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            squash_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            squash_q <= squash_d;
        end
    end

    assign count_o  = count_q;
    assign squash_o = squash_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generation stage feeding fetch: increment, stall, redirect and squash timing.
// Optional misaligned-redirect trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        fetch_pipeline_ctl_out,
    output logic        pc_valid_out,
    output logic        squash_out,
    output logic        misalign_err
);

    pc_state_t              state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic                   ctr_load, ctr_clear;
    logic [FLUSH_CTR_W-1:0] flush_count;
    logic                   squash;
    logic [31:0]            redirect_pc;

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign_q, misalign_set;
    logic target_misaligned;

    // A bad target is kept as-is so a debugger can see where control went.
    assign redirect_pc       = redirect_target;
    assign target_misaligned = |redirect_target[1:0];
`else
    logic unused_target_lsbs;

    assign redirect_pc        = align_word(redirect_target);
    assign unused_target_lsbs = ^redirect_target[1:0];
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        ctr_load  = 1'b0;
        ctr_clear = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misalign_set = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, FLUSH: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                    if (target_misaligned) begin
                        state_d      = HALT;
                        ctr_clear    = 1'b1;
                        misalign_set = 1'b1;
                    end else begin
                        state_d  = FLUSH;
                        ctr_load = 1'b1;
                    end
`else
                    state_d  = FLUSH;
                    ctr_load = 1'b1;
`endif
                end else begin
                    if (!stall_in) begin
                        pc_d    = pc_q + PC_STEP;
                        valid_d = 1'b1;
                    end
                    // Leave FLUSH on the edge where the counter steps down to one.
                    if (state_q == FLUSH && flush_count <= FLUSH_CTR_W'(2)) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                valid_d   = 1'b0;
                ctr_clear = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (misalign_set) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

    flush_ctr #(
        .LOAD_VALUE(FLUSH_CYCLES)
    ) u_flush_ctr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (ctr_load),
        .hold_i   (stall_in),
        .clear_i  (ctr_clear),
        .count_o  (flush_count),
        .squash_o (squash)
    );

    assign pc                     = pc_q;
    assign pc_valid_out           = valid_q;
    assign squash_out             = squash;
    assign fetch_pipeline_ctl_out = (state_q == RUN || state_q == FLUSH) && !stall_in;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: boot, increment, stall, redirect/squash timing,
// wrap-around, misaligned redirect and asynchronous reset.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallIn;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic [31:0] pcOut;
    logic        fetchEn;
    logic        pcValid;
    logic        squash;
    logic        misalignErr;

    int testCount = 0;
    int failCount = 0;

    pc_gen dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall_in               (stallIn),
        .redirect_valid         (redirectValid),
        .redirect_target        (redirectTarget),
        .pc                     (pcOut),
        .fetch_pipeline_ctl_out (fetchEn),
        .pc_valid_out           (pcValid),
        .squash_out             (squash),
        .misalign_err           (misalignErr)
    );

    always #5 clk = ~clk;

    // Inputs change just after a falling edge and settle before the next rising edge.
    task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] t);
        stallIn        = s;
        redirectValid  = rv;
        redirectTarget = t;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("reset_pc", pcOut, 32'h0);
        checkOutput("reset_valid", pcValid, 32'd0);
        checkOutput("reset_squash", squash, 32'd0);
        checkOutput("reset_fetch", fetchEn, 32'd0);
        checkOutput("reset_misalign", misalignErr, 32'd0);

        // Boot cycle, then sequential fetch of 0x0, 0x4, 0x8 ...
        rst = 1'b0;
        #1;
        checkOutput("boot_fetch", fetchEn, 32'd0);
        tick();
        checkOutput("run_pc0", pcOut, 32'h0);
        checkOutput("run_fetch", fetchEn, 32'd1);
        checkOutput("run_valid0", pcValid, 32'd0);
        tick();
        checkOutput("run_pc4", pcOut, 32'h4);
        checkOutput("run_valid1", pcValid, 32'd1);
        tick();
        checkOutput("run_pc8", pcOut, 32'h8);
        tick();
        tick();
        checkOutput("run_pc10", pcOut, 32'h10);

        // Three stalled cycles hold everything.
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stall_fetch", fetchEn, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("stall_pc", pcOut, 32'h10);
        checkOutput("stall_valid", pcValid, 32'd1);
        checkOutput("stall_fetch3", fetchEn, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("resume_pc", pcOut, 32'h14);
        for (int i = 0; i < 11; i++) tick();
        checkOutput("pre_redirect_pc", pcOut, 32'h40);

        // Single redirect: squash window of two cycles.
        applyStimulus(1'b0, 1'b1, 32'h200);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir_pc", pcOut, 32'h200);
        checkOutput("redir_valid", pcValid, 32'd0);
        checkOutput("redir_squash1", squash, 32'd1);
        checkOutput("redir_fetch", fetchEn, 32'd1);
        tick();
        checkOutput("redir_pc_next", pcOut, 32'h204);
        checkOutput("redir_valid_next", pcValid, 32'd1);
        checkOutput("redir_squash2", squash, 32'd1);
        tick();
        checkOutput("redir_squash_end", squash, 32'd0);
        checkOutput("redir_run_pc", pcOut, 32'h208);
        checkOutput("redir_run_fetch", fetchEn, 32'd1);

        // Redirect under stall, then a second redirect inside FLUSH restarts the window.
        applyStimulus(1'b1, 1'b1, 32'h300);
        checkOutput("stall_redir_fetch", fetchEn, 32'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("stall_redir_pc", pcOut, 32'h300);
        checkOutput("stall_redir_squash", squash, 32'd1);
        checkOutput("stall_redir_valid", pcValid, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h400);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redir2_pc", pcOut, 32'h400);
        checkOutput("redir2_squash1", squash, 32'd1);
        tick();
        checkOutput("redir2_pc_next", pcOut, 32'h404);
        checkOutput("redir2_squash2", squash, 32'd1);
        tick();
        checkOutput("redir2_squash_end", squash, 32'd0);
        checkOutput("redir2_pc_run", pcOut, 32'h408);

        // Wrap-around past the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrap_top", pcOut, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_zero", pcOut, 32'h0);
        tick();
        checkOutput("wrap_four", pcOut, 32'h4);

        // Misaligned redirect target.
        applyStimulus(1'b0, 1'b1, 32'h102);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        checkOutput("mis_pc", pcOut, 32'h102);
        checkOutput("mis_err", misalignErr, 32'd1);
        checkOutput("mis_fetch", fetchEn, 32'd0);
        checkOutput("mis_squash", squash, 32'd0);
        checkOutput("mis_valid", pcValid, 32'd0);
        tick();
        tick();
        checkOutput("halt_pc", pcOut, 32'h102);
        checkOutput("halt_fetch", fetchEn, 32'd0);
        checkOutput("halt_err", misalignErr, 32'd1);
`else
        checkOutput("mis_pc", pcOut, 32'h100);
        checkOutput("mis_err", misalignErr, 32'd0);
        checkOutput("mis_squash", squash, 32'd1);
        tick();
        checkOutput("mis_pc_next", pcOut, 32'h104);
        checkOutput("mis_fetch", fetchEn, 32'd1);
`endif

        // Asynchronous reset in the middle of a flush window.
        applyStimulus(1'b0, 1'b1, 32'h500);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
`ifndef PC_MISALIGN_TRAP_EN
        checkOutput("pre_rst_squash", squash, 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_pc", pcOut, 32'h0);
        checkOutput("async_rst_squash", squash, 32'd0);
        checkOutput("async_rst_valid", pcValid, 32'd0);
        checkOutput("async_rst_fetch", fetchEn, 32'd0);
        checkOutput("async_rst_err", misalignErr, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reboot_fetch", fetchEn, 32'd0);
        tick();
        checkOutput("reboot_run_fetch", fetchEn, 32'd1);
        tick();
        checkOutput("reboot_pc", pcOut, 32'h4);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generation stage, directly upstream of the fetch stage.
- Drives the fetch address and the fetch-enable strobe (fetch's fetch_pipeline_ctl_in). Sequential increment by 4, hazard stalls, execute-stage redirects (branch/jump).
- Emits a valid tag per fetched slot and a timed squash pulse so downstream stages can drop wrong-path instructions.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, cycles squash_out stays high after a redirect (fetch + decode depth); legal range 1..7.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_in  in  1  hazard hold from decode/execute; freezes PC and fetch.
- redirect_valid  in  1  taken branch/jump resolved in execute.
- redirect_target  in  32  new PC when redirect_valid=1.
- pc  out  32  fetch address, registered.
- fetch_pipeline_ctl_out  out  1  fetch-enable; fetch latches pc on the rising edge where this is 1.
- pc_valid_out  out  1  registered; 1 = slot latched by fetch at the last enabled edge is correct-path.
- squash_out  out  1  registered; 1 = downstream fetch/decode contents are wrong-path, drop them.
- misalign_err  out  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
- Reset, asynchronous, immediate: pc=RESET_VECTOR, state=BOOT, pc_valid_out=0, squash_out=0, flush counter=0, misalign_err=0.
- States: BOOT, RUN, FLUSH, HALT (pc_state_t).
- BOOT: exactly one cycle after rst deasserts. fetch_pipeline_ctl_out=0, pc unchanged, next state RUN. Redirect and stall are ignored in BOOT.
- fetch_pipeline_ctl_out is combinational: (state==RUN or FLUSH) and !stall_in.
- Per-edge priority in RUN/FLUSH: redirect > stall > increment.
  - redirect_valid=1: pc<=target; pc_valid_out<=0; counter<=FLUSH_CYCLES; squash_out<=1; state<=FLUSH. Applies even when stall_in=1.
  - Else stall_in=1: pc, pc_valid_out and squash_out hold. Counter keeps decrementing in FLUSH.
  - Else: pc<=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); pc_valid_out<=1.
- FLUSH:
  - Counter decrements each cycle; squash_out<=(counter>1).
  - Counter reaching 1 moves state to RUN at that edge.
  - A new redirect in FLUSH reloads the counter; the new target wins.
- Latency: redirect sampled at edge N, so pc=target after N and fetch latches target at edge N+1 (if not stalled).
- rst mid-FLUSH or mid-stall: all state discarded, restart from BOOT.
- HALT: fetch_pipeline_ctl_out=0, pc_valid_out=0, squash_out=0. Only rst exits HALT.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: a redirect with target[1:0]!=0 loads pc<=target unmodified (debug visibility), sets misalign_err=1 (sticky), and enters HALT. This takes priority over FLUSH entry.
- Undefined: target[1:0] is forced to 2'b00 before use, misalign_err is tied 0, and HALT is unreachable.

Decomposition:
- Shared package pipe_pkg: pc_state_t enum {BOOT, RUN, FLUSH, HALT}, localparam PC_STEP=32'd4, flush-counter width constant (3 bits).
- One sub-module, flush_ctr: loadable down-counter with squash output, instantiated once.
- The FSM and PC register stay in pc_gen.

Test Plan:
- Reset release, stall_in=0 → cycle1 fetch_pipeline_ctl_out=0 (BOOT); fetch latches 0x0, 0x4, 0x8 on consecutive edges; pc_valid_out=1 from the second enabled edge.
- stall_in=1 for 3 cycles at pc=0x10 → pc stays 0x10, fetch_pipeline_ctl_out=0, pc_valid_out holds 1; resume gives pc=0x14.
- redirect_valid pulse, target=0x200, at pc=0x40 → pc=0x200 next cycle; pc_valid_out=0 for that slot; squash_out=1 for exactly 2 cycles; state back to RUN.
- Redirect to 0x300 while stall_in=1, then a second redirect to 0x400 inside FLUSH → pc=0x400; squash_out window restarts (2 cycles from second redirect).
- pc=0xFFFF_FFFC, no stall → next pc=0x0000_0000.
- With PC_MISALIGN_TRAP_EN, redirect target=0x102 → misalign_err=1, pc=0x102, fetch_pipeline_ctl_out=0 permanently until rst. Without the macro: pc=0x100, misalign_err=0.
